// File: rtl/eviction_write_buffer_pkg.sv
// Shared types for the eviction write buffer: LC-3b word/line types and FSM state enums.
package eviction_write_buffer_pkg;

    typedef logic [15:0]  lc3b_word;
    typedef logic [127:0] lc3b_mem_data;
    typedef logic [11:0]  lc3b_c_vic_tag;

    typedef enum logic [1:0] {
        UP_IDLE  = 2'd0,
        UP_FETCH = 2'd1,
        UP_RESP  = 2'd2
    } lc3b_ewb_up_state;

    typedef enum logic [1:0] {
        DN_IDLE  = 2'd0,
        DN_DRAIN = 2'd1,
        DN_FETCH = 2'd2
    } lc3b_ewb_dn_state;

    function automatic lc3b_word lineAddr(input lc3b_c_vic_tag tag);
        return {tag, 4'b0000};
    endfunction

endpackage

// File: rtl/eviction_write_buffer_tag_cam.sv
// Tag/valid store for the buffered lines with a fully associative lookup.
// Reports a one-hot match vector, its encoded index, and whether the FIFO head matches.
module ewb_tag_cam
    import eviction_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IDXW  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                reset,
    input  lc3b_c_vic_tag       i_lookupTag,
    input  logic                i_allocEn,
    input  logic [IDXW-1:0]     i_allocIdx,
    input  lc3b_c_vic_tag       i_allocTag,
    input  logic                i_clearEn,
    input  logic [IDXW-1:0]     i_clearIdx,
    input  logic [IDXW-1:0]     i_headIdx,
    output logic [DEPTH-1:0]    o_matchVec,
    output logic [IDXW-1:0]     o_matchIdx,
    output logic                o_headMatch,
    output lc3b_c_vic_tag       o_headTag
);

    lc3b_c_vic_tag    r_tag [DEPTH];
    logic [DEPTH-1:0] r_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            if (i_clearEn) begin
                r_valid[i_clearIdx] <= 1'b0;
            end
            if (i_allocEn) begin
                r_valid[i_allocIdx] <= 1'b1;
                r_tag[i_allocIdx]   <= i_allocTag;
            end
        end
    end

    // At most one valid entry per tag exists, so a plain encoder is sufficient.
    always_comb begin
        o_matchVec = '0;
        o_matchIdx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            o_matchVec[i] = r_valid[i] && (r_tag[i] == i_lookupTag);
            if (o_matchVec[i]) begin
                o_matchIdx = IDXW'(i);
            end
        end
    end

    assign o_headMatch = o_matchVec[i_headIdx];
    assign o_headTag   = r_tag[i_headIdx];

endmodule

// File: rtl/eviction_write_buffer.sv
// Victim-cache writeback buffer: acks line writebacks immediately, drains them to memory,
// and forwards reads from buffered lines. Define EWB_COALESCE_EN to merge writes to a buffered tag.
module eviction_write_buffer
    import eviction_write_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          up_read,
    input  logic          up_write,
    input  lc3b_word      up_address,
    input  lc3b_mem_data  up_wdata,
    output lc3b_mem_data  up_rdata,
    output logic          up_resp,
    output logic          pmem_read,
    output logic          pmem_write,
    output lc3b_word      pmem_address,
    output lc3b_mem_data  pmem_wdata,
    input  lc3b_mem_data  pmem_rdata,
    input  logic          pmem_resp,
    output logic          full,
    output logic          empty
);

    localparam int PTRW = $clog2(DEPTH);
    localparam int CNTW = PTRW + 1;

    lc3b_ewb_up_state r_upState, w_upNext;
    lc3b_ewb_dn_state r_dnState, w_dnNext;

    logic [PTRW-1:0]  r_wrPtr, r_rdPtr;
    logic [CNTW-1:0]  r_count, w_nextCount;
    logic             r_full, r_empty;
    lc3b_mem_data     r_data [DEPTH];
    lc3b_mem_data     r_upRdata;

    lc3b_c_vic_tag    w_tag;
    logic [DEPTH-1:0] w_matchVec;
    logic [PTRW-1:0]  w_matchIdx;
    logic             w_headMatch;
    lc3b_c_vic_tag    w_headTag;
    logic             w_hit;
    logic             w_push, w_pop, w_coalesce, w_latchHit, w_fetchDone;
    logic             w_writeBlocked;

    assign w_tag       = up_address[15:4];
    assign w_hit       = |w_matchVec;
    assign w_fetchDone = (r_dnState == DN_FETCH) && pmem_resp;

    ewb_tag_cam #(.DEPTH(DEPTH), .IDXW(PTRW)) u_tagCam (
        .clk         (clk),
        .reset       (reset),
        .i_lookupTag (w_tag),
        .i_allocEn   (w_push),
        .i_allocIdx  (r_wrPtr),
        .i_allocTag  (w_tag),
        .i_clearEn   (w_pop),
        .i_clearIdx  (r_rdPtr),
        .i_headIdx   (r_rdPtr),
        .o_matchVec  (w_matchVec),
        .o_matchIdx  (w_matchIdx),
        .o_headMatch (w_headMatch),
        .o_headTag   (w_headTag)
    );

    // The line currently on the memory bus must not change under the drain.
    assign w_writeBlocked = r_full || (w_headMatch && (r_dnState == DN_DRAIN));

    always_comb begin
        w_upNext   = r_upState;
        w_push     = 1'b0;
        w_coalesce = 1'b0;
        w_latchHit = 1'b0;
        case (r_upState)
            UP_IDLE: begin
                if (up_read) begin
                    if (w_hit) begin
                        w_latchHit = 1'b1;
                        w_upNext   = UP_RESP;
                    end else begin
                        w_upNext   = UP_FETCH;
                    end
                end else if (up_write && !w_writeBlocked) begin
`ifdef EWB_COALESCE_EN
                    w_coalesce = w_hit;
                    w_push     = !w_hit;
                    w_upNext   = UP_RESP;
`else
                    if (!w_hit) begin
                        w_push   = 1'b1;
                        w_upNext = UP_RESP;
                    end
`endif
                end
            end
            UP_FETCH: begin
                if (w_fetchDone) begin
                    w_upNext = UP_RESP;
                end
            end
            UP_RESP:  w_upNext = UP_IDLE;
            default:  w_upNext = UP_IDLE;
        endcase
    end

    // Fetches are only considered from idle, so an in-flight drain always completes first.
    always_comb begin
        w_dnNext = r_dnState;
        w_pop    = 1'b0;
        case (r_dnState)
            DN_IDLE: begin
                if (r_upState == UP_FETCH) begin
                    w_dnNext = DN_FETCH;
                end else if (!r_empty) begin
                    w_dnNext = DN_DRAIN;
                end
            end
            DN_DRAIN: begin
                if (pmem_resp) begin
                    w_pop    = 1'b1;
                    w_dnNext = DN_IDLE;
                end
            end
            DN_FETCH: begin
                if (pmem_resp) begin
                    w_dnNext = DN_IDLE;
                end
            end
            default: w_dnNext = DN_IDLE;
        endcase
    end

    assign w_nextCount = r_count + CNTW'(w_push) - CNTW'(w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_upState <= UP_IDLE;
            r_dnState <= DN_IDLE;
            r_wrPtr   <= '0;
            r_rdPtr   <= '0;
            r_count   <= '0;
            r_full    <= 1'b0;
            r_empty   <= 1'b1;
            r_upRdata <= '0;
        end else begin
            r_upState <= w_upNext;
            r_dnState <= w_dnNext;
            r_count   <= w_nextCount;
            r_full    <= (w_nextCount == CNTW'(DEPTH));
            r_empty   <= (w_nextCount == '0);
            if (w_push) begin
                r_wrPtr <= r_wrPtr + PTRW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + PTRW'(1);
            end
            if (w_latchHit) begin
                r_upRdata <= r_data[w_matchIdx];
            end else if (w_fetchDone) begin
                r_upRdata <= pmem_rdata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_data[r_wrPtr] <= up_wdata;
        end else if (w_coalesce) begin
            r_data[w_matchIdx] <= up_wdata;
        end
    end

    always_comb begin
        pmem_address = '0;
        pmem_wdata   = '0;
        if (r_dnState == DN_FETCH) begin
            pmem_address = up_address & 16'hFFF0;
        end else if (r_dnState == DN_DRAIN) begin
            pmem_address = lineAddr(w_headTag);
            pmem_wdata   = r_data[r_rdPtr];
        end
    end

    assign pmem_read  = (r_dnState == DN_FETCH);
    assign pmem_write = (r_dnState == DN_DRAIN);
    assign up_resp    = (r_upState == UP_RESP);
    assign up_rdata   = r_upRdata;
    assign full       = r_full;
    assign empty      = r_empty;

endmodule

// File: tb/tb_eviction_write_buffer.sv
// Directed bench for eviction_write_buffer; the coalescing scenario follows EWB_COALESCE_EN.
module tb_eviction_write_buffer;

    logic         clk = 1'b0;
    logic         reset;
    logic         up_read, up_write;
    logic [15:0]  up_address;
    logic [127:0] up_wdata, up_rdata;
    logic         up_resp;
    logic         pmem_read, pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata, pmem_rdata;
    logic         pmem_resp;
    logic         full, empty;

    int testsRun = 0;
    int testsFailed = 0;

    localparam logic [127:0] D0 = 128'hD0D0_0000_1111_2222_3333_4444_5555_6666;
    localparam logic [127:0] DA = 128'hAAAA_0001_0000_0000_0000_0000_0000_000A;
    localparam logic [127:0] DB = 128'hBBBB_0002_0000_0000_0000_0000_0000_000B;
    localparam logic [127:0] DC = 128'hCCCC_0003_0000_0000_0000_0000_0000_000C;
    localparam logic [127:0] DD = 128'hDDDD_0004_0000_0000_0000_0000_0000_000D;
    localparam logic [127:0] DE = 128'hEEEE_0005_0000_0000_0000_0000_0000_000E;
    localparam logic [127:0] D1 = 128'h1111_1111_ABCD_0000_0000_0000_0000_0001;
    localparam logic [127:0] D5 = 128'h5555_5555_ABCD_0000_0000_0000_0000_0005;
    localparam logic [127:0] RD = 128'h7777_7777_FEED_BEEF_0123_4567_89AB_CDEF;
    localparam logic [127:0] D2 = 128'h2222_2222_0000_0000_0000_0000_0000_0002;
    localparam logic [127:0] D3 = 128'h3333_3333_0000_0000_0000_0000_0000_0003;
    localparam logic [127:0] D9 = 128'h9999_9999_0000_0000_0000_0000_0000_0009;
    localparam logic [127:0] DF = 128'hBEE0_BEE0_0000_0000_0000_0000_0000_00BE;

    eviction_write_buffer #(.DEPTH(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .up_read      (up_read),
        .up_write     (up_write),
        .up_address   (up_address),
        .up_wdata     (up_wdata),
        .up_rdata     (up_rdata),
        .up_resp      (up_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp),
        .full         (full),
        .empty        (empty)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        testsRun++;
        assert (observed === expected) else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic isRead, input logic [15:0] addr, input logic [127:0] data,
                                 input int maxCycles, output int latency, output logic [127:0] rdata);
        up_address = addr;
        up_wdata   = data;
        up_read    = isRead;
        up_write   = !isRead;
        latency    = 0;
        rdata      = '0;
        do begin
            @(negedge clk);
            latency++;
        end while (!up_resp && latency < maxCycles);
        if (up_resp) rdata = up_rdata;
        else latency = -1;
        up_read  = 1'b0;
        up_write = 1'b0;
        @(negedge clk);
    endtask

    task automatic pulseResp();
        pmem_resp = 1'b1;
        @(negedge clk);
        pmem_resp = 1'b0;
    endtask

    task automatic waitDrain(input string tag, input logic [15:0] addr, input logic [127:0] data);
        int cyc = 0;
        while (!pmem_write && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput({tag, "_seen"}, 128'(pmem_write), 128'(1'b1));
        checkOutput({tag, "_addr"}, 128'(pmem_address), 128'(addr));
        checkOutput({tag, "_data"}, pmem_wdata, data);
        if (pmem_write) pulseResp();
    endtask

    initial begin
        int lat;
        int cyc;
        logic [127:0] rd;

        reset      = 1'b1;
        up_read    = 1'b0;
        up_write   = 1'b0;
        up_address = '0;
        up_wdata   = '0;
        pmem_rdata = '0;
        pmem_resp  = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("rst_up_resp", 128'(up_resp), 128'(1'b0));
        checkOutput("rst_empty", 128'(empty), 128'(1'b1));
        checkOutput("rst_full", 128'(full), 128'(1'b0));
        checkOutput("rst_pmem_write", 128'(pmem_write), 128'(1'b0));
        checkOutput("rst_pmem_read", 128'(pmem_read), 128'(1'b0));
        checkOutput("rst_up_rdata", up_rdata, 128'(0));
        reset = 1'b0;
        @(negedge clk);

        // Single writeback: immediate ack, then drained to memory
        applyStimulus(1'b0, 16'h1230, D0, 10, lat, rd);
        checkOutput("t1_ack_lat", 128'(lat), 128'(1));
        waitDrain("t1_drain", 16'h1230, D0);
        checkOutput("t1_empty", 128'(empty), 128'(1'b1));

        // Fill the buffer behind a stalled memory, 5th write waits for the first drain
        applyStimulus(1'b0, 16'h1000, DA, 10, lat, rd);
        checkOutput("t2_ack_a", 128'(lat), 128'(1));
        applyStimulus(1'b0, 16'h2000, DB, 10, lat, rd);
        checkOutput("t2_ack_b", 128'(lat), 128'(1));
        applyStimulus(1'b0, 16'h3000, DC, 10, lat, rd);
        checkOutput("t2_ack_c", 128'(lat), 128'(1));
        applyStimulus(1'b0, 16'h4000, DD, 10, lat, rd);
        checkOutput("t2_ack_d", 128'(lat), 128'(1));
        checkOutput("t2_full", 128'(full), 128'(1'b1));
        up_address = 16'h5000;
        up_wdata   = DE;
        up_write   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("t2_full_stall", 128'(up_resp), 128'(1'b0));
        end
        checkOutput("t2_head_addr", 128'(pmem_address), 128'(16'h1000));
        checkOutput("t2_head_data", pmem_wdata, DA);
        pulseResp();
        checkOutput("t2_full_clear", 128'(full), 128'(1'b0));
        cyc = 0;
        while (!up_resp && cyc < 5) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("t2_ack_e", 128'(up_resp), 128'(1'b1));
        up_write = 1'b0;
        @(negedge clk);
        waitDrain("t2_drain_b", 16'h2000, DB);
        waitDrain("t2_drain_c", 16'h3000, DC);
        waitDrain("t2_drain_d", 16'h4000, DD);
        waitDrain("t2_drain_e", 16'h5000, DE);

        // Read hits forward buffered data in one cycle
        applyStimulus(1'b0, 16'h4560, D1, 10, lat, rd);
        checkOutput("t3_ack_1", 128'(lat), 128'(1));
        applyStimulus(1'b0, 16'h5550, D5, 10, lat, rd);
        checkOutput("t3_ack_5", 128'(lat), 128'(1));
        applyStimulus(1'b1, 16'h4568, '0, 10, lat, rd);
        checkOutput("t3_hit_lat", 128'(lat), 128'(1));
        checkOutput("t3_hit_data", rd, D1);
        checkOutput("t3_no_pmem_read", 128'(pmem_read), 128'(1'b0));
        applyStimulus(1'b1, 16'h555C, '0, 10, lat, rd);
        checkOutput("t3_hit2_data", rd, D5);

        // Read miss waits behind the in-flight drain, then beats the next drain
        up_address = 16'h7770;
        up_read    = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("t4_read_held", 128'(pmem_read), 128'(1'b0));
        end
        checkOutput("t4_drain_addr", 128'(pmem_address), 128'(16'h4560));
        pulseResp();
        cyc = 0;
        while (!pmem_read && cyc < 5) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("t4_pmem_read", 128'(pmem_read), 128'(1'b1));
        checkOutput("t4_fetch_addr", 128'(pmem_address), 128'(16'h7770));
        checkOutput("t4_fetch_first", 128'(pmem_write), 128'(1'b0));
        pmem_rdata = RD;
        pulseResp();
        checkOutput("t4_resp", 128'(up_resp), 128'(1'b1));
        checkOutput("t4_rdata", up_rdata, RD);
        up_read    = 1'b0;
        pmem_rdata = '0;
        @(negedge clk);
        waitDrain("t4_drain_5", 16'h5550, D5);

        // Second write to a buffered tag
        applyStimulus(1'b0, 16'h9000, D9, 10, lat, rd);
        checkOutput("t5_ack_9", 128'(lat), 128'(1));
        applyStimulus(1'b0, 16'hA000, D2, 10, lat, rd);
        checkOutput("t5_ack_2", 128'(lat), 128'(1));
`ifdef EWB_COALESCE_EN
        applyStimulus(1'b0, 16'hA000, D3, 10, lat, rd);
        checkOutput("t5_coalesce_ack", 128'(lat), 128'(1));
        applyStimulus(1'b1, 16'hA000, '0, 10, lat, rd);
        checkOutput("t5_read_d3", rd, D3);
        waitDrain("t5_drain_9", 16'h9000, D9);
        waitDrain("t5_drain_a", 16'hA000, D3);
        repeat (3) @(negedge clk);
        checkOutput("t5_single_drain", 128'(pmem_write), 128'(1'b0));
        checkOutput("t5_empty", 128'(empty), 128'(1'b1));
`else
        up_address = 16'hA000;
        up_wdata   = D3;
        up_write   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checkOutput("t5_dup_stall", 128'(up_resp), 128'(1'b0));
        end
        waitDrain("t5_drain_9", 16'h9000, D9);
        checkOutput("t5_dup_stall2", 128'(up_resp), 128'(1'b0));
        waitDrain("t5_drain_2", 16'hA000, D2);
        cyc = 0;
        while (!up_resp && cyc < 5) begin
            @(negedge clk);
            cyc++;
        end
        checkOutput("t5_dup_ack", 128'(up_resp), 128'(1'b1));
        up_write = 1'b0;
        @(negedge clk);
        applyStimulus(1'b1, 16'hA000, '0, 10, lat, rd);
        checkOutput("t5_read_d3", rd, D3);
        waitDrain("t5_drain_3", 16'hA000, D3);
`endif

        // Asynchronous reset in the middle of a drain discards the buffer
        applyStimulus(1'b0, 16'hC000, DA, 10, lat, rd);
        applyStimulus(1'b0, 16'hC100, DB, 10, lat, rd);
        applyStimulus(1'b0, 16'hC200, DC, 10, lat, rd);
        checkOutput("t6_pre_drain", 128'(pmem_write), 128'(1'b1));
        #2;
        reset = 1'b1;
        #1;
        checkOutput("t6_rst_pmem_write", 128'(pmem_write), 128'(1'b0));
        checkOutput("t6_rst_empty", 128'(empty), 128'(1'b1));
        checkOutput("t6_rst_addr", 128'(pmem_address), 128'(0));
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        applyStimulus(1'b0, 16'hBEE0, DF, 10, lat, rd);
        checkOutput("t6_new_ack", 128'(lat), 128'(1));
        waitDrain("t6_new_drain", 16'hBEE0, DF);
        checkOutput("t6_final_empty", 128'(empty), 128'(1'b1));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
